// File: rtl/puf_resp_packer.sv
// puf_resp_packer: triggers an oscillator PUF, tags each 96-bit response with a 32-bit header
// and packs four tagged responses per 512-bit AXI4-Stream beat under output flow control.
module puf_resp_packer #(
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_RESP_WIDTH  = 96,
    parameter int C_COUNT_WIDTH = 32,
    parameter int C_TIMEOUT     = 4096
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     ctrl_start,
    input  logic [C_COUNT_WIDTH-1:0] ctrl_num_responses,
    output logic                     ctrl_done,
    output logic                     puf_trig,
    input  logic [2:0]               puf_state,
    input  logic [C_RESP_WIDTH-1:0]  puf_out,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                     m_axis_tlast
);
    localparam int SW = C_DATA_WIDTH / 4;
    localparam int TW = $clog2(C_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(C_TIMEOUT - 1);
    localparam logic [C_COUNT_WIDTH-1:0] ONE = C_COUNT_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, CAPTURE, REARM, FLUSH, DONE} state_t;

    state_t                   state_q, state_d;
    logic [C_COUNT_WIDTH-1:0] n_q, n_d, idx_q, idx_d;
    logic [1:0]               ptr_q, ptr_d;
    logic [C_DATA_WIDTH-1:0]  acc_q, acc_d, tdata_q, tdata_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     to_q, to_d, trig_q, trig_d, done_q, done_d;
    logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                     resp_ok, out_free, last_resp;
    logic [SW-1:0]            slot;

    assign resp_ok   = puf_state == 3'b100;
    assign out_free  = !tvalid_q || m_axis_tready;
    assign last_resp = idx_q + ONE == n_q;
    assign slot      = {8'hA5, to_q, 7'd0, idx_q[15:0], to_q ? {C_RESP_WIDTH{1'b1}} : puf_out};
    assign trig_d    = state_d == WAIT;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        acc_d    = acc_q;
        tmo_d    = tmo_q;
        to_d     = to_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (ctrl_start) begin
                n_d     = ctrl_num_responses;
                idx_d   = '0;
                ptr_d   = '0;
                acc_d   = '0;
                state_d = ctrl_num_responses == '0 ? DONE : TRIG;
            end
            TRIG: begin
                tmo_d   = TO_LOAD;
                state_d = WAIT;
            end
            WAIT: if (resp_ok) begin
                to_d    = 1'b0;
                state_d = CAPTURE;
            end else if (tmo_q == '0) begin
                to_d    = 1'b1;
                state_d = CAPTURE;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
            CAPTURE: begin
                acc_d[ptr_q*SW +: SW] = slot;
                idx_d   = idx_q + ONE;
                ptr_d   = ptr_q + 2'd1;
                state_d = (ptr_q == 2'd3 || last_resp) ? FLUSH : REARM;
            end
            REARM: if (!resp_ok) state_d = TRIG;
            // Reload is allowed in the same cycle the previous beat is accepted.
            FLUSH: if (out_free) begin
                tvalid_d = 1'b1;
                tdata_d  = acc_q;
                tlast_d  = idx_q == n_q;
                acc_d    = '0;
                ptr_d    = '0;
                state_d  = idx_q == n_q ? DONE : REARM;
            end
            DONE: if (out_free) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            acc_q    <= '0;
            tmo_q    <= '0;
            to_q     <= 1'b0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            to_q     <= to_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign ctrl_done     = done_q;
    assign puf_trig      = trig_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
endmodule
